// File: rtl/mdu_ctrl.sv
// mdu_ctrl: multiply/divide unit controller for the P7 pipelined core.
// Accepts mult/multu/div/divu/mthi/mtlo from E, runs the fixed-latency
// operation, owns HI/LO and raises the D-stage stall for MD-class
// instructions that would meet a busy unit.
//
// Ports:
//   clk     in   system clock, rising edge
//   reset   in   asynchronous, active-high
//   md_op   in   [3:0] 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo
//   rs_val  in   [31:0] rs operand (dividend / multiplicand / mthi-mtlo data)
//   rt_val  in   [31:0] rt operand
//   flush   in   cancels the E-stage op this cycle
//   D_MDen  in   instruction in D uses the MD unit
//   busy    out  operation in flight
//   start   out  mult/div accepted this cycle (combinational)
//   stall   out  D_MDen & (busy | start)
//   hi, lo  out  [31:0] HI / LO registers
//
// Build option: MDU_DIV0_GUARD_EN -- when defined, divide by zero leaves
// hi/lo unchanged at commit; otherwise lo=0xFFFFFFFF, hi=rs_val.
//
// state | meaning
// IDLE  | ready; accepts mult/div, performs mthi/mtlo writes
// BUSY  | operation in flight, cnt counts down to commit

module mdu_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  md_op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        flush,
  input  logic        D_MDen,
  output logic        busy,
  output logic        start,
  output logic        stall,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  localparam int MAX_CYC = (MULT_CYCLES > DIV_CYCLES) ? MULT_CYCLES : DIV_CYCLES;
  localparam int CW      = $clog2(MAX_CYC) + 1;
  localparam logic [CW-1:0] MULT_LOAD = CW'(MULT_CYCLES - 1);
  localparam logic [CW-1:0] DIV_LOAD  = CW'(DIV_CYCLES - 1);

  typedef enum logic {IDLE, BUSY} state_t;

  state_t        state, state_nx;
  logic [CW-1:0] cnt, cnt_nx;
  logic [31:0]   pend_hi, pend_lo, pend_hi_nx, pend_lo_nx;
  logic [31:0]   hi_nx, lo_nx;

  // arithmetic datapath
  logic [63:0] prod_s, prod_u;
  logic [31:0] abs_a, abs_b, div_b, qm, rm;
  logic [31:0] q_s, r_s, q_u, r_u;
  logic [31:0] res_hi, res_lo;
  logic        is_mul, is_div;

  assign is_mul = (md_op == 4'd1) || (md_op == 4'd2);
  assign is_div = (md_op == 4'd3) || (md_op == 4'd4);

  // The low 64 bits of the product of sign-extended operands is the signed product.
  assign prod_s = {{32{rs_val[31]}}, rs_val} * {{32{rt_val[31]}}, rt_val};
  assign prod_u = {32'd0, rs_val} * {32'd0, rt_val};

  // Signed divide via magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  assign abs_a = rs_val[31] ? (32'd0 - rs_val) : rs_val;
  assign abs_b = rt_val[31] ? (32'd0 - rt_val) : rt_val;
  assign div_b = (abs_b == 32'd0) ? 32'd1 : abs_b;
  assign qm    = abs_a / div_b;
  assign rm    = abs_a % div_b;
  assign q_s   = (rs_val[31] ^ rt_val[31]) ? (32'd0 - qm) : qm;
  assign r_s   = rs_val[31] ? (32'd0 - rm) : rm;
  assign q_u   = rs_val / ((rt_val == 32'd0) ? 32'd1 : rt_val);
  assign r_u   = rs_val % ((rt_val == 32'd0) ? 32'd1 : rt_val);

  always_comb begin
    res_hi = 32'd0;
    res_lo = 32'd0;
    case (md_op)
      4'd1: {res_hi, res_lo} = prod_s;
      4'd2: {res_hi, res_lo} = prod_u;
      4'd3: begin res_hi = r_s; res_lo = q_s; end
      4'd4: begin res_hi = r_u; res_lo = q_u; end
      default: ;
    endcase
    if (is_div && (rt_val == 32'd0)) begin
`ifdef MDU_DIV0_GUARD_EN
      // hi/lo cannot change while BUSY, so committing the current values is a no-op
      res_hi = hi;
      res_lo = lo;
`else
      res_hi = rs_val;
      res_lo = 32'hFFFF_FFFF;
`endif
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= IDLE;
      cnt     <= '0;
      pend_hi <= 32'd0;
      pend_lo <= 32'd0;
      hi      <= 32'd0;
      lo      <= 32'd0;
    end else begin
      state   <= state_nx;
      cnt     <= cnt_nx;
      pend_hi <= pend_hi_nx;
      pend_lo <= pend_lo_nx;
      hi      <= hi_nx;
      lo      <= lo_nx;
    end
  end

  always_comb begin
    state_nx   = state;
    cnt_nx     = cnt;
    pend_hi_nx = pend_hi;
    pend_lo_nx = pend_lo;
    hi_nx      = hi;
    lo_nx      = lo;
    start      = 1'b0;
    case (state)
      IDLE: begin
        if (!flush) begin
          if (is_mul || is_div) begin
            start      = 1'b1;
            pend_hi_nx = res_hi;
            pend_lo_nx = res_lo;
            cnt_nx     = is_div ? DIV_LOAD : MULT_LOAD;
            state_nx   = BUSY;
          end else if (md_op == 4'd5) begin
            hi_nx = rs_val;
          end else if (md_op == 4'd6) begin
            lo_nx = rs_val;
          end
        end
      end
      BUSY: begin
        // flush is ignored here: the op in flight is older and already committed
        if (cnt == '0) begin
          hi_nx    = pend_hi;
          lo_nx    = pend_lo;
          state_nx = IDLE;
        end else begin
          cnt_nx = cnt - 1'b1;
        end
      end
      default: state_nx = IDLE;
    endcase
  end

  assign busy  = (state == BUSY);
  assign stall = D_MDen & (busy | start);

endmodule

// File: tb/tb_mdu_ctrl.sv
module tb_mdu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [3:0]  md_op;
  logic [31:0] rs_val, rt_val;
  logic        flush, D_MDen;
  logic        busy, start, stall;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_err    = 0;
  logic [31:0] m_hi, m_lo;

  mdu_ctrl #(.MULT_CYCLES(5), .DIV_CYCLES(10)) dut (
    .clk(clk), .reset(reset), .md_op(md_op), .rs_val(rs_val), .rt_val(rt_val),
    .flush(flush), .D_MDen(D_MDen), .busy(busy), .start(start), .stall(stall),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // No mult/div may be presented while the unit is busy.
  always @(negedge clk) begin
    if (busy && !reset) begin
      assert (!(md_op inside {4'd1, 4'd2, 4'd3, 4'd4})) else begin
        n_err++;
        $error("FAIL op_in_busy: observed md_op=%0d expected none", md_op);
      end
    end
  end

  // Accept an op, hold D_MDen, count BUSY cycles (bounded), check commit.
  task automatic run_op(input string tag, input logic [3:0] op,
                        input logic [31:0] a, input logic [31:0] b,
                        input int exp_n, input logic [31:0] eh, input logic [31:0] el,
                        input logic flush_in_busy);
    int n;
    md_op = op; rs_val = a; rt_val = b; D_MDen = 1'b1; flush = 1'b0;
    #1;
    check({tag, "_start"}, 32'(start), 32'd1);
    check({tag, "_stall_acc"}, 32'(stall), 32'd1);
    tick();
    md_op = 4'd0; flush = flush_in_busy;
    n = 0;
    while (busy && n < 40) begin
      #1;
      check({tag, "_stall_busy"}, 32'(stall), 32'd1);
      check({tag, "_hi_hold"}, hi, m_hi);
      check({tag, "_lo_hold"}, lo, m_lo);
      n++;
      tick();
    end
    flush = 1'b0;
    check({tag, "_busy_cycles"}, 32'(n), 32'(exp_n));
    check({tag, "_busy_after"}, 32'(busy), 32'd0);
    check({tag, "_stall_after"}, 32'(stall), 32'd0);
    m_hi = eh; m_lo = el;
    check({tag, "_hi"}, hi, m_hi);
    check({tag, "_lo"}, lo, m_lo);
  endtask

  initial begin
    reset = 1'b1; md_op = 4'd0; rs_val = 32'd0; rt_val = 32'd0;
    flush = 1'b0; D_MDen = 1'b0;
    m_hi = 32'd0; m_lo = 32'd0;
    tick();
    check("rst_busy",  32'(busy),  32'd0);
    check("rst_start", 32'(start), 32'd0);
    check("rst_stall", 32'(stall), 32'd0);
    check("rst_hi", hi, 32'd0);
    check("rst_lo", lo, 32'd0);
    reset = 1'b0;
    tick();

    // illegal op codes behave as none
    md_op = 4'd7; D_MDen = 1'b1; #1;
    check("op7_start", 32'(start), 32'd0);
    check("op7_stall", 32'(stall), 32'd0);
    md_op = 4'd15; tick();
    check("op15_busy", 32'(busy), 32'd0);

    run_op("mult",  4'd1, 32'd3, 32'hFFFF_FFFE, 5, 32'hFFFF_FFFF, 32'hFFFF_FFFA, 1'b0);
    run_op("multu", 4'd2, 32'd3, 32'hFFFF_FFFE, 5, 32'h0000_0002, 32'hFFFF_FFFA, 1'b0);
    run_op("div",   4'd3, 32'hFFFF_FFF9, 32'd2, 10, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0);
    run_op("divu",  4'd4, 32'd7, 32'd2, 10, 32'd1, 32'd3, 1'b0);
    run_op("div_ovf", 4'd3, 32'h8000_0000, 32'hFFFF_FFFF, 10, 32'd0, 32'h8000_0000, 1'b0);
    // flush during BUSY must not abort; 0x10000 * 0x10000 = 1<<32
    run_op("mult_fl", 4'd1, 32'h0001_0000, 32'h0001_0000, 5, 32'd1, 32'd0, 1'b1);

    // flushed mult never starts
    md_op = 4'd1; rs_val = 32'd9; rt_val = 32'd9; flush = 1'b1; D_MDen = 1'b0; #1;
    check("flush_start", 32'(start), 32'd0);
    tick();
    check("flush_busy", 32'(busy), 32'd0);
    check("flush_hi", hi, m_hi);
    check("flush_lo", lo, m_lo);

    // flushed mtlo dropped, unflushed mtlo visible next cycle
    md_op = 4'd6; rs_val = 32'h0000_1234; flush = 1'b1; tick();
    check("mtlo_fl_lo", lo, m_lo);
    flush = 1'b0; tick();
    md_op = 4'd0;
    m_lo = 32'h0000_1234;
    check("mtlo_lo", lo, m_lo);
    check("mtlo_busy", 32'(busy), 32'd0);
    md_op = 4'd5; rs_val = 32'hABCD_0001; tick();
    md_op = 4'd0;
    m_hi = 32'hABCD_0001;
    check("mthi_hi", hi, m_hi);
    check("mthi_lo", lo, m_lo);

    // divide by zero
`ifdef MDU_DIV0_GUARD_EN
    run_op("div0",  4'd3, 32'd5, 32'd0, 10, m_hi, m_lo, 1'b0);
    run_op("divu0", 4'd4, 32'd5, 32'd0, 10, m_hi, m_lo, 1'b0);
`else
    run_op("div0",  4'd3, 32'd5, 32'd0, 10, 32'd5, 32'hFFFF_FFFF, 1'b0);
    run_op("divu0", 4'd4, 32'd6, 32'd0, 10, 32'd6, 32'hFFFF_FFFF, 1'b0);
`endif

    // reset in the fourth BUSY cycle of a div
    md_op = 4'd3; rs_val = 32'd100; rt_val = 32'd7; D_MDen = 1'b0; tick();
    md_op = 4'd0;
    tick(); tick(); tick();
    check("rmid_busy_pre", 32'(busy), 32'd1);
    #2 reset = 1'b1; #1;
    check("rmid_busy", 32'(busy), 32'd0);
    check("rmid_hi", hi, 32'd0);
    check("rmid_lo", lo, 32'd0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 12; i++) tick();
    check("rmid_late_busy", 32'(busy), 32'd0);
    check("rmid_late_hi", hi, 32'd0);
    check("rmid_late_lo", lo, 32'd0);
    m_hi = 32'd0; m_lo = 32'd0;

    // unit usable again after reset
    run_op("div_post", 4'd3, 32'd100, 32'd7, 10, 32'd2, 32'd14, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/mdu_ctrl.md
# mdu_ctrl

Multiply/divide unit controller for the P7 pipelined MIPS core. Accepts mult/multu/div/divu/mthi/mtlo from the E stage, sequences the fixed-latency multi-cycle operation, owns the HI/LO registers, and generates the D-stage stall whenever a decoded MD-class instruction (MDen) would meet a busy unit. Sits beside the E-stage ALU; HI/LO reads feed the E-stage result mux for mfhi/mflo.

## Interface
- MULT_CYCLES, 5: busy cycles for mult/multu (≥1)
- DIV_CYCLES, 10: busy cycles for div/divu (≥1)

- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- md_op  in  4  E-stage op: 0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7–15 treated as none
- rs_val  in  32  forwarded rs operand (dividend / multiplicand / mthi-mtlo data)
- rt_val  in  32  forwarded rt operand
- flush  in  1  exception/eret taken this cycle; cancels E-stage op
- D_MDen  in  1  instruction in D uses the MD unit (incl. mfhi/mflo)
- busy  out  1  operation in flight
- start  out  1  mult/div accepted this cycle (combinational)
- stall  out  1  D_MDen & (busy | start)
- hi  out  32  HI register
- lo  out  32  LO register

## Operation
- States: IDLE, BUSY. Down-counter cnt (width ≥ clog2(max latency)+1).
- IDLE: md_op ∈ {1..4}, flush=0 → start=1; latch result into pend_hi/pend_lo; cnt←N-1 (N per op); → BUSY. mthi/mtlo with flush=0 → write hi/lo at this edge, stay IDLE.
- BUSY: cnt decrements each cycle; at cnt=0 edge hi←pend_hi, lo←pend_lo, → IDLE. md_op ignored in BUSY (stall guarantees none arrives; bench asserts this).
- flush=1 suppresses start and mthi/mtlo writes; never aborts an op already in BUSY (it belongs to an older, committed instruction).
- Arithmetic: mult = signed 32×32→64, multu unsigned; {hi,lo}={high,low}. div: lo=signed quotient truncated toward zero, hi=remainder with sign of dividend; divu unsigned. 0x80000000/−1 → lo=0x80000000, hi=0.
- hi/lo outputs hold old values throughout BUSY; new values visible only after commit.

## Timing
- Reset: state=IDLE, cnt=0, busy=0, hi=lo=0, pend=0; start/stall follow inputs combinationally (0 when md_op=0, D_MDen=0).
- Accept at edge T → busy=1 from T+1 through T+N; hi/lo updated at edge T+N; busy=0 in cycle after.
- Back-to-back: new op may be accepted in the first IDLE cycle after commit.
- mthi/mtlo: visible on hi/lo the cycle after the write edge; zero busy.
- stall is combinational; high in acceptance cycle and all BUSY cycles when D_MDen=1.
- Reset mid-operation: pending result discarded, hi/lo=0 immediately.

## Configuration
- MDU_DIV0_GUARD_EN defined: div/divu with rt_val=0 still occupies DIV_CYCLES busy but hi/lo are left unchanged at commit.
- Undefined: divide-by-zero commits lo=0xFFFFFFFF, hi=rs_val (both div and divu).

## Test plan
- mult rs=3, rt=0xFFFFFFFE → busy 5 cycles, then hi=0xFFFFFFFF, lo=0xFFFFFFFA; multu same operands → hi=0x00000002, lo=0xFFFFFFFA.
- div rs=0xFFFFFFF9 (−7), rt=2 → after 10 cycles lo=0xFFFFFFFD, hi=0xFFFFFFFF; divu 7/2 → lo=3, hi=1.
- mult accepted, D_MDen=1 held → stall=1 in accept cycle plus 5 BUSY cycles, 0 after; hi/lo unchanged until commit.
- md_op=mult with flush=1 → start=0, busy never rises, hi/lo unchanged; mtlo 0x1234 with flush=1 → lo unchanged, flush=0 → lo=0x1234 next cycle.
- div in flight, reset pulsed at busy cycle 4 → busy=0, hi=lo=0 immediately; no late commit.
- div 5/0 → with MDU_DIV0_GUARD_EN hi/lo unchanged after 10 cycles; without, lo=0xFFFFFFFF, hi=5.
